// File: rtl/sram22_param_1rw.sv
// Parametrised 1RW SRAM model with request handshake, post-reset clear and byte-lane style write mask.
// Define SRAM22_OUT_REG_EN to add a second read register stage (read latency 2).
module sram22_param_1rw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int MASK_GRAN = 4,
    localparam int WMASK_WIDTH = DATA_WIDTH / MASK_GRAN,
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   init_busy
);

    // state   | meaning
    // ST_INIT | clearing one word per cycle, requests ignored
    // ST_RUN  | accepting one read or write per cycle
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    generate
        if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
            $fatal(1, "sram22_param_1rw: MASK_GRAN must divide DATA_WIDTH");
        end
    endgenerate

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  init_addr;
    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]  bit_mask;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic                   acc_wr;
    logic                   acc_rd;

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < WMASK_WIDTH; k++) begin
            bit_mask[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask[k]}};
        end
    end

    assign wr_word = (mem[addr] & ~bit_mask) | (din & bit_mask);
    assign acc_wr  = req_valid & req_ready & we;
    assign acc_rd  = req_valid & req_ready & ~we;

`ifdef SRAM22_OUT_REG_EN
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
`endif

    // Array contents are deliberately left alone in the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            rsp_valid <= 1'b0;
            dout      <= '0;
`ifdef SRAM22_OUT_REG_EN
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`endif
        end else begin
            if (state == ST_INIT) begin
                mem[init_addr] <= '0;
                init_addr      <= init_addr + ADDR_WIDTH'(1);
                if (init_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state     <= ST_RUN;
                    req_ready <= 1'b1;
                    init_busy <= 1'b0;
                end
            end else if (acc_wr) begin
                mem[addr] <= wr_word;
            end
`ifdef SRAM22_OUT_REG_EN
            rd_valid_q <= acc_rd;
            if (acc_rd) begin
                rd_data_q <= mem[addr];
            end
            rsp_valid <= rd_valid_q;
            if (rd_valid_q) begin
                dout <= rd_data_q;
            end
`else
            rsp_valid <= acc_rd;
            if (acc_rd) begin
                dout <= mem[addr];
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram22_param_1rw.sv
// Scoreboard bench for sram22_param_1rw: directed spec cases plus randomized traffic against an array model.
module tb_sram22_param_1rw;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int MG = 4;
    localparam int MW = DW / MG;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM22_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [MW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rsp_valid;
    logic [DW-1:0] dout;
    logic          init_busy;

    sram22_param_1rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(MG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .we        (we),
        .wmask     (wmask),
        .addr      (addr),
        .din       (din),
        .rsp_valid (rsp_valid),
        .dout      (dout),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        logic [AW-1:0] a;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd = '0;
    int            checks = 0;
    int            errors = 0;

    // Monitor: every response is popped against the scoreboard; idle cycles must hold dout.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 dout=%h, required no response", dout);
                end else begin
                    e = sb.pop_front();
                    if (dout !== e.data || cycle_cnt != e.due) begin
                        errors++;
                        $display("FAIL read_addr_%0d: got dout=%h at cycle %0d, required dout=%h at cycle %0d",
                                 e.a, dout, cycle_cnt, e.data, e.due);
                    end
                    last_rd = e.data;
                end
            end else if (dout !== last_rd) begin
                errors++;
                $display("FAIL dout_hold: got dout=%h, required %h", dout, last_rd);
            end
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input bit has_exp, input logic [DW-1:0] exp_d);
        req_valid = 1'b1;
        we        = w;
        addr      = a;
        din       = d;
        wmask     = m;
        if (req_ready) begin
            if (w) begin
                for (int k = 0; k < MW; k++) begin
                    if (m[k]) model[a][k*MG +: MG] = d[k*MG +: MG];
                end
            end else begin
                sb.push_back('{data: (has_exp ? exp_d : model[a]), due: cycle_cnt + LAT, a: a});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        sb.delete();
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        checks++;
        if (rsp_valid !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rsp_valid=%b dout=%h, required 0 and 0", rsp_valid, dout);
        end
        checks++;
        if (req_ready !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got req_ready=%b init_busy=%b, required 0 and 1", req_ready, init_busy);
        end
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered at the negedge where rst_n rises; counts posedges until req_ready.
    task automatic wait_init();
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (req_ready) break;
            if (init_busy !== 1'b1) busy_ok = 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_length: got %0d cycles, required %0d", n, DEPTH);
        end
        checks++;
        if (!busy_ok || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_busy: got final init_busy=%b (held=%b), required 0 after high throughout",
                     init_busy, busy_ok);
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        we        = 1'b0;
        addr      = '0;
        din       = '0;
        wmask     = '0;
        #2;
        apply_reset(3);

        // A write presented during the clear must be ignored.
        req_valid = 1'b1;
        we        = 1'b1;
        addr      = 6'd9;
        din       = 32'hA5A5A5A5;
        wmask     = 8'hFF;
        wait_init();

        for (int i = 0; i < DEPTH; i++) issue(1'b0, AW'(i), '0, '0, 1'b1, 32'h0);

        issue(1'b1, 6'd5, 32'hDEADBEEF, 8'hFF, 1'b0, '0);
        issue(1'b0, 6'd5, '0, '0, 1'b1, 32'hDEADBEEF);
        issue(1'b1, 6'd5, 32'h12345678, 8'h0F, 1'b0, '0);
        issue(1'b0, 6'd5, '0, '0, 1'b1, 32'hDEAD5678);
        issue(1'b1, 6'd5, 32'hFFFFFFFF, 8'h00, 1'b0, '0);
        issue(1'b0, 6'd5, '0, '0, 1'b1, 32'hDEAD5678);
        idle(2);

        issue(1'b1, 6'd1, 32'h11, 8'hFF, 1'b0, '0);
        issue(1'b1, 6'd2, 32'h22, 8'hFF, 1'b0, '0);
        issue(1'b1, 6'd3, 32'h33, 8'hFF, 1'b0, '0);
        issue(1'b0, 6'd1, '0, '0, 1'b1, 32'h11);
        issue(1'b0, 6'd2, '0, '0, 1'b1, 32'h22);
        issue(1'b0, 6'd3, '0, '0, 1'b1, 32'h33);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) idle(1);
            else issue((r < 5), AW'($urandom_range(0, DEPTH - 1)), $urandom,
                       MW'($urandom_range(0, (1 << MW) - 1)), 1'b0, '0);
        end
        idle(4);

        // Reset with a read in flight: response must be dropped and the array cleared again.
        issue(1'b1, 6'd5, 32'hCAFEF00D, 8'hFF, 1'b0, '0);
        issue(1'b0, 6'd5, '0, '0, 1'b1, 32'hCAFEF00D);
        idle(3);
        req_valid = 1'b1;
        we        = 1'b0;
        addr      = 6'd5;
        @(posedge clk);
        #2;
        apply_reset(3);
        wait_init();
        issue(1'b0, 6'd5, '0, '0, 1'b1, 32'h0);
        issue(1'b0, 6'd9, '0, '0, 1'b1, 32'h0);
        idle(1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding reads, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
